// File: rtl/stream_select_mux.sv
// stream_select_mux: takes one select token and one type token, then routes exactly one
// packet from the selected input to the output, tagging each beat. Optional: STREAM_SELECT_BEAT_COUNT_EN.
module stream_select_mux #(
    parameter int NUM_SELECT   = 4,
    parameter int DATA_WIDTH   = 64,
    parameter int TYPE_WIDTH   = 4,
    parameter int SELECT_WIDTH = $clog2(NUM_SELECT)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             sel_valid,
    output logic                             sel_ready,
    input  logic [SELECT_WIDTH-1:0]          sel_data,
    input  logic                             type_valid,
    output logic                             type_ready,
    input  logic [TYPE_WIDTH-1:0]            type_data,
    input  logic [NUM_SELECT-1:0]            in_valid,
    output logic [NUM_SELECT-1:0]            in_ready,
    input  logic [NUM_SELECT*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_SELECT-1:0]            in_last,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic                             out_last,
    output logic [TYPE_WIDTH-1:0]            out_type,
    output logic                             state_dbg,
`ifdef STREAM_SELECT_BEAT_COUNT_EN
    output logic [31:0]                      beat_count,
    output logic [31:0]                      pkt_count,
`endif
    output logic                             sel_err
);

    // Every channel uses ready/valid: a transfer happens on a rising clk edge where both
    // valid and ready are 1; a source holds valid and its payload steady until that edge.

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    localparam logic [SELECT_WIDTH:0] SEL_LIMIT = (SELECT_WIDTH + 1)'(NUM_SELECT);

    state_t                  state;
    state_t                  state_next;
    logic [SELECT_WIDTH-1:0] sel_hold;
    logic                    sel_full;
    logic [TYPE_WIDTH-1:0]   type_hold;
    logic                    type_full;
    logic [TYPE_WIDTH-1:0]   type_q;
    logic                    active;
    logic                    both_full;
    logic                    sel_in_range;
    logic                    pair_go;
    logic                    pair_bad;
    logic                    mux_valid;
    logic [DATA_WIDTH-1:0]   mux_data;
    logic                    mux_last;
    logic                    out_hs;
    logic                    pkt_done;

    assign active     = (state == ACTIVE);
    assign both_full  = sel_full & type_full;
    assign sel_ready  = (state == IDLE) & ~sel_full;
    assign type_ready = (state == IDLE) & ~type_full;
    assign state_dbg  = active;

    // Next-state decision; an out-of-range select is consumed without ever going ACTIVE.
    always_comb begin
        state_next   = state;
        pair_go      = 1'b0;
        pair_bad     = 1'b0;
        sel_in_range = ({1'b0, sel_hold} < SEL_LIMIT);
        unique case (state)
            IDLE: begin
                if (both_full) begin
                    if (sel_in_range) begin
                        pair_go    = 1'b1;
                        state_next = ACTIVE;
                    end else begin
                        pair_bad = 1'b1;
                    end
                end
            end
            ACTIVE: begin
                if (pkt_done) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Compare-based mux so an index beyond NUM_SELECT never reads past the bus.
    always_comb begin
        mux_valid = 1'b0;
        mux_data  = '0;
        mux_last  = 1'b0;
        in_ready  = '0;
        for (int i = 0; i < NUM_SELECT; i++) begin
            if (sel_hold == SELECT_WIDTH'(i)) begin
                mux_valid   = in_valid[i];
                mux_data    = in_data[i*DATA_WIDTH +: DATA_WIDTH];
                mux_last    = in_last[i];
                in_ready[i] = active & out_ready;
            end
        end
    end

    assign out_valid = active & mux_valid;
    assign out_data  = mux_data;
    assign out_last  = active & mux_last;
    assign out_type  = type_q;
    assign out_hs    = out_valid & out_ready;
    assign pkt_done  = out_hs & out_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sel_hold  <= '0;
            sel_full  <= 1'b0;
            type_hold <= '0;
            type_full <= 1'b0;
            type_q    <= '0;
            sel_err   <= 1'b0;
        end else begin
            state <= state_next;
            if (sel_valid & sel_ready) begin
                sel_hold <= sel_data;
                sel_full <= 1'b1;
            end else if (pkt_done | pair_bad) begin
                sel_full <= 1'b0;
            end
            if (type_valid & type_ready) begin
                type_hold <= type_data;
                type_full <= 1'b1;
            end else if (pkt_done | pair_bad) begin
                type_full <= 1'b0;
            end
            // The tag is latched so new type tokens in IDLE do not disturb out_type.
            if (pair_go) begin
                type_q <= type_hold;
            end
            if (pair_bad) begin
                sel_err <= 1'b1;
            end
        end
    end

`ifdef STREAM_SELECT_BEAT_COUNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_count <= '0;
            pkt_count  <= '0;
        end else begin
            if (pair_go) begin
                beat_count <= '0;
            end else if (out_hs) begin
                beat_count <= beat_count + 32'd1;
            end
            if (pkt_done) begin
                pkt_count <= pkt_count + 32'd1;
            end
        end
    end
`endif

endmodule
